// File: rtl/barrett_for_1889_if.sv
// barrett_for_1889_if: operand/result handshake bundle for the mod-1889 Barrett reducer.
`timescale 1ns/1ps
interface barrett_for_1889_if;
    logic        in_valid;
    logic [20:0] din_a;
    logic        out_valid;
    logic [10:0] dout_r;
    modport master (output in_valid, din_a, input out_valid, dout_r);
    modport slave (input in_valid, din_a, output out_valid, dout_r);
endinterface

// File: rtl/barrett_for_1889.sv
// barrett_for_1889: registered din_a mod 1889 via Barrett quotient estimate plus two corrections.
// Define BARRETT_PIPE_EN for the 3-stage pipeline (latency 3); default is single stage (latency 1).
`timescale 1ns/1ps
module barrett_for_1889 (
    input logic                clk,
    input logic                rst_n,
    barrett_for_1889_if.slave  s_bus
);
    localparam int MOD   = 1889;
    localparam int IN_W  = 21;
    localparam int OUT_W = 11;
    localparam int SHIFT = 22;
    localparam int MU    = 2220;
    localparam int R_W   = OUT_W + 2;
    logic [OUT_W-1:0] w_q, w_rq, w_res;
    logic [IN_W-1:0]  w_ra;
    logic [R_W-1:0]   w_r, w_rc, w_c1;
    logic [OUT_W-1:0] r_dout;
    logic             r_out_valid;
    // Only the upper bits of the product matter, so the quotient is taken straight from it.
    assign w_q   = OUT_W'((33'(s_bus.din_a) * 33'(MU)) >> SHIFT);
    assign w_r   = R_W'(w_ra - IN_W'(w_rq) * IN_W'(MOD));
    assign w_c1  = (w_rc >= R_W'(MOD)) ? w_rc - R_W'(MOD) : w_rc;
    assign w_res = (w_c1 >= R_W'(MOD)) ? OUT_W'(w_c1 - R_W'(MOD)) : w_c1[OUT_W-1:0];
`ifdef BARRETT_PIPE_EN
    logic [OUT_W-1:0] r_q;
    logic [IN_W-1:0]  r_a;
    logic [R_W-1:0]   r_r;
    logic             r_v1, r_v2;
    assign w_ra = r_a;
    assign w_rq = r_q;
    assign w_rc = r_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            r_a         <= '0;
            r_r         <= '0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_v1        <= s_bus.in_valid;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            if (s_bus.in_valid) begin
                r_q <= w_q;
                r_a <= s_bus.din_a;
            end
            if (r_v1) r_r <= w_r;
            if (r_v2) r_dout <= w_res;
        end
    end
`else
    assign w_ra = s_bus.din_a;
    assign w_rq = w_q;
    assign w_rc = w_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= s_bus.in_valid;
            if (s_bus.in_valid) r_dout <= w_res;
        end
    end
`endif
    assign s_bus.out_valid = r_out_valid;
    assign s_bus.dout_r    = r_dout;
endmodule

// File: tb/tb_barrett_for_1889.sv
// tb_barrett_for_1889: directed + scoreboarded check of the mod-1889 reducer in either build.
`timescale 1ns/1ps
module tb_barrett_for_1889;
`ifdef BARRETT_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_q[$];
    logic [10:0] last_dout = '0;

    barrett_for_1889_if bus ();
    barrett_for_1889 dut (.clk(clk), .rst_n(rst_n), .s_bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input int d, input int e);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.din_a    = 21'(d);
        if (v) exp_q.push_back(e);
    endtask

    // Scoreboard: every out_valid pops one expected value in order; gaps must hold dout_r.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) check("spurious_valid", 1, 0);
                else check("result", bus.dout_r, exp_q.pop_front());
            end else check("hold", bus.dout_r, last_dout);
        end
        last_dout = bus.dout_r;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        int  d;
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.din_a = 21'd1234;
        repeat (3) @(negedge clk);
        check("rst_dout", bus.dout_r, 0);
        check("rst_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(1234);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) seen = 1;
        end
        check("latency", n, LAT);
        for (int i = 0; i < 1889; i++) drive(1, i, i);
        drive(0, 0, 0);
        drive(1, 1889, 0);
        drive(1, 1890, 1);
        drive(0, 7, 0);
        drive(1, 3777, 1888);
        drive(1, 3778, 0);
        drive(0, 0, 0);
        drive(1, 2097151, 361);
        drive(1, 2096790, 0);
        for (int i = 0; i < 2000; i++) begin
            d = int'($urandom_range(0, 2097151));
            drive(logic'($urandom_range(0, 2) != 0), d, d % 1889);
        end
        drive(0, 0, 0);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        drive(1, 100, 100);
        drive(1, 2000, 111);
        drive(1, 5000, 1222);
        drive(1, 5674, 7);
        drive(1, 1888, 1888);
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_dout", bus.dout_r, 0);
        check("midrst_valid", bus.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        drive(1, 3779, 1);
        drive(0, 0, 0);
        repeat (LAT + 3) @(posedge clk);
        check("final_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
